// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus bundle between the APB master and the register-file completer
interface apb_slave_regfile_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslaverr;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslaverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslaverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with register file, programmable wait states and decode errors; APB_SLV_WRPROT_EN makes PROT_BASE..DEPTH-1 read-only
module apb_slave_regfile #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_BASE   = 48
) (
    input logic pclk,
    input logic preset,
    apb_slave_regfile_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PROT_A  = (ADDR_W+1)'(PROT_BASE);
`ifdef APB_SLV_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q, err_q;
    logic [DATA_W-1:0] wdata_q, prdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              setup, done, load, wr_en, valid_in, err_in;
    logic [DATA_W-1:0] rd_in;

    // setup decode, completion, error classification and read-data source (with write forwarding)
    always_comb begin
        setup    = bus.psel & ~bus.penable;
        done     = (state_q == ACCESS) && (cnt_q == 4'd0) && bus.psel;
        wr_en    = done & wr_q & ~err_q;
        valid_in = {1'b0, bus.paddr} < DEPTH_A;
        err_in   = ~valid_in | (WRPROT & bus.pwrite & ({1'b0, bus.paddr} >= PROT_A));
        rd_in    = !valid_in ? '0 : (wr_en && addr_q == bus.paddr) ? wdata_q : mem_q[bus.paddr[AW-1:0]];
        bus.pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
        bus.pslaverr = bus.pready & err_q;
        bus.prdata   = prdata_q;
    end

    // next state: start on setup, count wait states, abort on psel drop, relatch on back-to-back setup
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        if (state_q == IDLE) begin
            load = setup;
        end else if (!bus.psel) begin
            state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
            cnt_d = bus.penable ? cnt_q - 4'd1 : cnt_q;
        end else begin
            load    = setup;
            state_d = IDLE;
        end
        if (load) begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_CYCLES);
        end
    end

    // FSM state and wait counter
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // setup-latched transfer attributes, read data and register file writes
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            addr_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (load) begin
                addr_q   <= bus.paddr;
                wr_q     <= bus.pwrite;
                err_q    <= err_in;
                wdata_q  <= bus.pwdata;
                prdata_q <= rd_in;
            end
            if (wr_en) mem_q[addr_q[AW-1:0]] <= wdata_q;
        end
    end
endmodule
